// File: rtl/switch_pkg.sv
// Shared constants and read-segment decode for the switch input peripheral.
package switch_pkg;

  localparam int unsigned SW_W   = 24;
  localparam int unsigned DATA_W = 16;

  localparam logic [19:0] DB_CYCLES_DEFAULT = 20'd200000;

  localparam logic [1:0] SW_LO_ADDR   = 2'b00;
  localparam logic [1:0] SW_FLAG_ADDR = 2'b01;
  localparam logic [1:0] SW_HI_ADDR   = 2'b10;

  // Maps a segment address onto the 16-bit read bus; unmapped segments read as zero.
  function automatic logic [DATA_W-1:0] seg_data(input logic [1:0]      addr,
                                                 input logic [SW_W-1:0] sw,
                                                 input logic            flag);
    logic [DATA_W-1:0] d;
    d = '0;
    case (addr)
      SW_LO_ADDR:   d = sw[15:0];
      SW_HI_ADDR:   d = {8'h00, sw[23:16]};
      SW_FLAG_ADDR: d = {15'd0, flag};
      default:      d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus stability counter; commits a new switch word once it has held steady.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int unsigned     DB_W      = 20,
  parameter logic [DB_W-1:0] DB_CYCLES = DB_W'(DB_CYCLES_DEFAULT)
) (
  input  logic            switch_clk,
  input  logic            switchrst,
  input  logic [SW_W-1:0] switch_i,
  output logic [SW_W-1:0] sw_db,
  output logic            commit_c
);

  localparam logic [DB_W-1:0] DB_MAX = DB_CYCLES - DB_W'(1);

  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;
  logic [SW_W-1:0] sw_last;
  logic [DB_W-1:0] db_cnt;
  logic            stable_c;

  // A saturated counter alone would commit on the first cycle of a new value,
  // so the commit also requires the current sample to match the previous one.
  assign stable_c = (sw_sync == sw_last);
  assign commit_c = stable_c && (db_cnt == DB_MAX) && (sw_sync != sw_db);

  always_ff @(posedge switch_clk) begin
    if (switchrst) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw_last <= '0;
      db_cnt  <= '0;
      sw_db   <= '0;
    end else begin
      sw_meta <= switch_i;
      sw_sync <= sw_meta;
      sw_last <= sw_sync;
      if (!stable_c) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_MAX) begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      if (commit_c) begin
        sw_db <= sw_sync;
      end
    end
  end

endmodule

// File: rtl/switch_reader.sv
// Memory-mapped switch reader: debounced switch word, sticky change flag, registered read data.
module switch_reader
  import switch_pkg::*;
#(
  parameter int unsigned     DB_W      = 20,
  parameter logic [DB_W-1:0] DB_CYCLES = DB_W'(DB_CYCLES_DEFAULT)
) (
  input  logic              switch_clk,
  input  logic              switchrst,
  input  logic              switchread,
  input  logic              switchcs,
  input  logic [1:0]        switchaddr,
  input  logic [SW_W-1:0]   switch_i,
  output logic [DATA_W-1:0] switchrdata,
  output logic              sw_changed
);

  logic [SW_W-1:0] sw_db;
  logic            commit_c;
  logic            rd_c;

  switch_debounce #(
    .DB_W      (DB_W),
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .switch_clk (switch_clk),
    .switchrst  (switchrst),
    .switch_i   (switch_i),
    .sw_db      (sw_db),
    .commit_c   (commit_c)
  );

  assign rd_c = switchcs && switchread;

  // Set beats clear so a commit coinciding with a flag read is never lost.
  always_ff @(posedge switch_clk) begin
    if (switchrst) begin
      switchrdata <= '0;
      sw_changed  <= 1'b0;
    end else begin
      if (rd_c) begin
        switchrdata <= seg_data(switchaddr, sw_db, sw_changed);
      end
      if (commit_c) begin
        sw_changed <= 1'b1;
      end else if (rd_c && (switchaddr == SW_FLAG_ADDR)) begin
        sw_changed <= 1'b0;
      end
    end
  end

endmodule
